// File: rtl/universal_shift_engine.sv
// Universal shift engine: WIDTH-bit register with load/hold and six shift/rotate
// modes, driven by a start/ready/done handshake that runs a programmed number of
// 1-bit steps per command. The bit leaving the register on each step is exposed.
module universal_shift_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic [CNT_W-1:0] amount,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             enable,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             ser_out
);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_LSL  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   step_res;   // {bit shifted out, next register value}

    // One 1-bit step of the latched operation: returns {ser_out, q_next}
    function automatic logic [WIDTH:0] step_fn(input logic [2:0]       o,
                                               input logic [WIDTH-1:0] v,
                                               input logic             si_msb,
                                               input logic             si_lsb);
        logic [WIDTH:0] r;
        case (o)
            OP_SHR:  r = {v[0],       si_msb,     v[WIDTH-1:1]};
            OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], si_lsb};
            OP_ROR:  r = {v[0],       v[0],       v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ASR:  r = {v[0],       v[WIDTH-1], v[WIDTH-1:1]};
            OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    // Candidate result of a step taken on this edge
    always_comb begin
        step_res = step_fn(op_q, q, msb_in, lsb_in);
    end

    // Handshake status decoded straight from the state register
    assign ready = (state == IDLE);
    assign busy  = ~ready;

    // Command FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_HOLD;
            cnt     <= '0;
            q       <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_HOLD || op == OP_LOAD) begin
                            if (op == OP_LOAD) begin
                                q <= d;
                            end
                            done <= 1'b1;
                        end else if (amount == '0) begin
                            done <= 1'b1;
                        end else begin
                            op_q  <= op;
                            cnt   <= amount;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (enable) begin
                        ser_out <= step_res[WIDTH];
                        q       <= step_res[WIDTH-1:0];
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
